// File: rtl/div_if.sv
// div_if: operand/result handshake bundle for the sequential divider.
//   master : drives in_valid, a, b, unsign, out_ready; sees in_ready,
//            out_valid, quotient, remainder.
//   slave  : the divider side of the same signals.
interface div_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             unsign;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output in_valid, a, b, unsign, out_ready,
        input  in_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  in_valid, a, b, unsign, out_ready,
        output in_ready, out_valid, quotient, remainder
    );
endinterface

// File: rtl/div.sv
// div: sequential radix-2 restoring integer divider, signed or unsigned.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : div_if.slave -- operands (a, b, unsign) in over in_valid/in_ready,
//          quotient/remainder out over out_valid/out_ready
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// PREP  | take magnitudes and signs, catch divide-by-zero and signed overflow
// CALC  | one quotient bit per cycle, MSB first, WIDTH cycles
// FIX   | apply result signs (special-case results pass through unchanged)
// DONE  | out_valid high, results held until out_ready
module div #(
    parameter int WIDTH = 16
) (
    input logic   clk,
    input logic   rst,
    div_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r, b_r;
    logic             unsign_r;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] dvd;       // dividend bits shift out, quotient bits shift in
    logic [WIDTH:0]   rem;       // partial remainder
    logic [CW-1:0]    cnt;
    logic             q_neg, r_neg, special;
    logic [WIDTH-1:0] quot_r, rem_r;
    logic             in_ready_r, out_valid_r;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b_c;
    logic [WIDTH:0]   shifted, diff;

    always_comb begin
        a_neg   = !unsign_r && a_r[WIDTH-1];
        b_neg   = !unsign_r && b_r[WIDTH-1];
        mag_a   = a_neg ? -a_r : a_r;
        mag_b_c = b_neg ? -b_r : b_r;
        shifted = {rem[WIDTH-1:0], dvd[WIDTH-1]};
        diff    = shifted - {1'b0, mag_b};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            unsign_r    <= 1'b0;
            mag_b       <= '0;
            dvd         <= '0;
            rem         <= '0;
            cnt         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            special     <= 1'b0;
            quot_r      <= '0;
            rem_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r        <= bus.a;
                        b_r        <= bus.b;
                        unsign_r   <= bus.unsign;
                        in_ready_r <= 1'b0;
                        state      <= PREP;
                    end
                end
                PREP: begin
                    q_neg <= a_neg ^ b_neg;
                    r_neg <= a_neg;
                    dvd   <= mag_a;
                    mag_b <= mag_b_c;
                    rem   <= '0;
                    cnt   <= '0;
                    // Special results are loaded here and ride through FIX
                    // untouched, so they surface two edges after accept.
                    if (b_r == '0) begin
                        quot_r  <= '1;
                        rem_r   <= a_r;
                        special <= 1'b1;
                        state   <= FIX;
                    end else if (!unsign_r && a_r == {1'b1, {(WIDTH-1){1'b0}}} && b_r == '1) begin
                        quot_r  <= a_r;
                        rem_r   <= '0;
                        special <= 1'b1;
                        state   <= FIX;
                    end else begin
                        special <= 1'b0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    // diff MSB set means the trial subtraction went negative
                    rem <= diff[WIDTH] ? shifted : diff;
                    dvd <= {dvd[WIDTH-2:0], !diff[WIDTH]};
                    if (cnt == CW'(WIDTH-1)) begin
                        cnt   <= '0;
                        state <= FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (!special) begin
                        quot_r <= q_neg ? -dvd : dvd;
                        rem_r  <= (r_neg && rem != '0) ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    end
                    out_valid_r <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.quotient  = quot_r;
    assign bus.remainder = rem_r;
endmodule
